motor_speed_scheduler: RTL and testbench
========================================

Name: motor_speed_scheduler

Overview:
- Sequences the duty-cycle and direction inputs of the left and right PWM motor channels.
- Arbitrates between two requesters:
  - the black-line follower, which issues continuous low-priority speed targets;
  - the maneuver sequencer, which issues high-priority timed turn/reverse commands over a valid/ready handshake.
- Applies a slew-rate ramp to every duty change and reverses a channel's direction only after its duty reaches 0.
- An emergency-stop input overrides both requesters.

Parameters:
- DUTY_W, 4: width of a duty code; 0 = off, 15 = maximum on-time.
- RAMP_DIV, 3125: clk_3125KHz cycles per ramp tick (1 ms at 3.125 MHz).
- RAMP_STEP, 1: maximum duty change per channel per ramp tick.
- HOLD_W, 8: width of the maneuver hold count, in ramp ticks.

Ports:
- clk_3125KHz  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- estop  in  1  level; forces both duties to 0 while high.
- lf_valid  in  1  line-follower target update strobe.
- lf_duty_left  in  DUTY_W  line-follower left target.
- lf_duty_right  in  DUTY_W  line-follower right target.
- cmd_valid  in  1  maneuver command valid.
- cmd_ready  out  1  scheduler can accept a maneuver.
- cmd_duty_left  in  DUTY_W  maneuver left target.
- cmd_duty_right  in  DUTY_W  maneuver right target.
- cmd_dir_left  in  1  maneuver left direction (1 = forward).
- cmd_dir_right  in  1  maneuver right direction (1 = forward).
- cmd_hold  in  HOLD_W  ramp ticks to hold once both targets are reached.
- cmd_done  out  1  one-cycle pulse: maneuver completed.
- cmd_abort  out  1  one-cycle pulse: maneuver killed by estop.
- duty_left  out  DUTY_W  to left PWM channel.
- duty_right  out  DUTY_W  to right PWM channel.
- dir_left  out  1  left H-bridge direction.
- dir_right  out  1  right H-bridge direction.
- busy  out  1  high in MANEUVER, HOLD or STOP.

Behaviour:
- Reset (rst sampled high at a clk_3125KHz edge):
  - state = FOLLOW;
  - duty_left = duty_right = 0; dir_left = dir_right = 1;
  - line-follower target registers = 0, direction forward;
  - prescaler = 0, hold counter = 0;
  - cmd_done = cmd_abort = 0, busy = 0.
  - Reset applies identically mid-ramp, mid-maneuver and in STOP; no pulses are emitted.
- cmd_ready = (state == FOLLOW) && !estop, combinational. A command is accepted when cmd_valid && cmd_ready at a clock edge. All cmd_* fields are latched at that edge.
- Line-follower targets are latched on every lf_valid, in every state, including the cycle a command is accepted. They take effect whenever the state is FOLLOW.
- Ramp tick:
  - The prescaler counts 0..RAMP_DIV-1; tick = 1 for one cycle when the prescaler is at RAMP_DIV-1.
  - Duty and direction change only on tick cycles, except on estop.
- Per-channel ramp rule, applied on each tick against (target_duty, target_dir):
  - If dir != target_dir and duty > 0: duty = duty - min(RAMP_STEP, duty).
  - Else if dir != target_dir and duty == 0: dir = target_dir; duty unchanged.
  - Else move duty toward target by at most RAMP_STEP, clamping exactly at the target. No overshoot and no wrap (unsigned saturating).
  - A channel is "settled" when dir == target_dir and duty == target_duty.
- FOLLOW:
  - Targets are the latched line-follower values, direction forward.
  - On command accept, go to MANEUVER.
- MANEUVER:
  - Targets are the latched command values.
  - On the first tick on which both channels are settled after the update, load hold counter = cmd_hold and go to HOLD.
- HOLD:
  - Decrement the hold counter on each tick.
  - When the counter is 0 at a tick (including cmd_hold = 0): assert cmd_done for that cycle, then go to FOLLOW on the next edge.
  - The ramp toward line-follower targets resumes from the next tick.
- STOP:
  - estop high in any state, at an edge, sets duty_left = duty_right = 0 immediately, with no ramp. Directions are held.
  - If the state was MANEUVER or HOLD, cmd_abort pulses for one cycle.
  - State = STOP until estop is sampled low, then FOLLOW. Ramping up restarts from 0.
- Simultaneous events:
  - estop beats cmd_valid, because cmd_ready is low.
  - estop beats a pending cmd_done: cmd_abort is emitted, not cmd_done.
  - A command accepted on a tick cycle is first applied on the following tick.
  - cmd_done and cmd_abort are never high together.
- Latency:
  - A target change is visible on duty_* at the next tick edge.
  - From rest, a full direction reversal at duty d with RAMP_STEP = 1 takes d + 1 + d' ticks, where d' is the new target duty.

Decomposition:
- Shared package motor_ctrl_pkg holds:
  - DUTY_W;
  - direction constants DIR_FWD = 1, DIR_REV = 0;
  - the state enum FOLLOW / MANEUVER / HOLD / STOP.
- Sub-module duty_ramp_channel (one per motor) owns:
  - inputs: tick, estop-clear, target_duty, target_dir;
  - the duty and dir registers;
  - the settled output.
- The top level owns the prescaler, the FSM, the hold counter, the target muxing and the handshake.

Test Plan (bench uses RAMP_DIV = 4, RAMP_STEP = 1):
- Reset, then lf_valid with left = 10, right = 6 → duties step +1 every 4 cycles; right holds at 6 after 6 ticks, left reaches 10 after 10 ticks; cmd_ready stays 1 throughout.
- Line follower settled at 5/5, then a command with left = 8 fwd, right = 3 rev, hold = 2:
  - left ramps 5→8 over 3 ticks;
  - right ramps 5→0, flips dir_right = 0, then ramps 0→3;
  - then 2 hold ticks, a cmd_done pulse, and the ramp back toward 5/5 fwd.
- estop during HOLD with duties 8/3 → both duties 0 at the next edge and one cmd_abort pulse; with estop held, lf_valid has no effect on the outputs; after estop release, duties ramp up from 0.
- cmd_valid together with estop, and cmd_valid while busy → no accept, no cmd_done; the latched targets are unchanged.
- A command with hold = 0 and targets equal to the current duties → cmd_done within 2 ticks.
- rst asserted mid-reversal → all outputs at reset values on the next edge; no pulses.

Source files
------------

// File: rtl/motor_ctrl_pkg.sv
// Shared types and constants for the motor speed scheduler and its ramp channels.
package motor_ctrl_pkg;

  localparam int DUTY_W = 4;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef enum logic [1:0] {
    FOLLOW,
    MANEUVER,
    HOLD,
    STOP
  } sched_state_t;

endpackage

// File: rtl/duty_ramp_channel.sv
// One PWM channel: slews duty toward a target and only flips direction at zero duty.
module duty_ramp_channel
  import motor_ctrl_pkg::*;
#(
  parameter int RAMP_STEP = 1
) (
  input  logic              clk_3125KHz,
  input  logic              rst,
  input  logic              tick,
  input  logic              estop,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              target_dir,
  output logic [DUTY_W-1:0] duty,
  output logic              dir,
  output logic              settled
);

  localparam logic [DUTY_W-1:0] STEP = DUTY_W'(RAMP_STEP);

  logic [DUTY_W-1:0] duty_next;
  logic              dir_next;

  always_comb begin
    duty_next = duty;
    dir_next  = dir;
    if (dir != target_dir) begin
      if (duty > STEP)
        duty_next = duty - STEP;
      else if (duty != '0)
        duty_next = '0;
      else
        dir_next = target_dir;
    end else if (duty < target_duty) begin
      if ((target_duty - duty) > STEP)
        duty_next = duty + STEP;
      else
        duty_next = target_duty;
    end else if (duty > target_duty) begin
      if ((duty - target_duty) > STEP)
        duty_next = duty - STEP;
      else
        duty_next = target_duty;
    end
  end

  // Reports the state the channel will be in after this tick's update.
  assign settled = (dir_next == target_dir) && (duty_next == target_duty);

  always_ff @(posedge clk_3125KHz) begin
    if (rst) begin
      duty <= '0;
      dir  <= DIR_FWD;
    end else if (estop) begin
      duty <= '0;
    end else if (tick) begin
      duty <= duty_next;
      dir  <= dir_next;
    end
  end

endmodule

// File: rtl/motor_speed_scheduler.sv
// Arbitrates line-follower targets against timed maneuvers and drives both ramped PWM channels.
module motor_speed_scheduler
  import motor_ctrl_pkg::*;
#(
  parameter int RAMP_DIV  = 3125,
  parameter int RAMP_STEP = 1,
  parameter int HOLD_W    = 8
) (
  input  logic              clk_3125KHz,
  input  logic              rst,
  input  logic              estop,
  input  logic              lf_valid,
  input  logic [DUTY_W-1:0] lf_duty_left,
  input  logic [DUTY_W-1:0] lf_duty_right,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_duty_left,
  input  logic [DUTY_W-1:0] cmd_duty_right,
  input  logic              cmd_dir_left,
  input  logic              cmd_dir_right,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              cmd_done,
  output logic              cmd_abort,
  output logic [DUTY_W-1:0] duty_left,
  output logic [DUTY_W-1:0] duty_right,
  output logic              dir_left,
  output logic              dir_right,
  output logic              busy
);

  localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);

  sched_state_t      state;
  logic [PRE_W-1:0]  prescaler;
  logic              tick;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DUTY_W-1:0] lf_left_q, lf_right_q;
  logic [DUTY_W-1:0] cmd_left_q, cmd_right_q;
  logic              cmd_dir_left_q, cmd_dir_right_q;
  logic [HOLD_W-1:0] cmd_hold_q;
  logic [DUTY_W-1:0] tgt_duty_left, tgt_duty_right;
  logic              tgt_dir_left, tgt_dir_right;
  logic              settled_left, settled_right;
  logic              accept;

  assign tick      = (prescaler == PRE_LAST);
  assign cmd_ready = (state == FOLLOW) && !estop;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != FOLLOW);

  always_ff @(posedge clk_3125KHz) begin
    if (rst || tick)
      prescaler <= '0;
    else
      prescaler <= prescaler + 1'b1;
  end

  // A maneuver owns the channels until its hold expires; every other state follows the line.
  always_comb begin
    tgt_duty_left  = lf_left_q;
    tgt_duty_right = lf_right_q;
    tgt_dir_left   = DIR_FWD;
    tgt_dir_right  = DIR_FWD;
    if (state == MANEUVER || state == HOLD) begin
      tgt_duty_left  = cmd_left_q;
      tgt_duty_right = cmd_right_q;
      tgt_dir_left   = cmd_dir_left_q;
      tgt_dir_right  = cmd_dir_right_q;
    end
  end

  always_ff @(posedge clk_3125KHz) begin
    if (rst) begin
      state           <= FOLLOW;
      hold_cnt        <= '0;
      lf_left_q       <= '0;
      lf_right_q      <= '0;
      cmd_left_q      <= '0;
      cmd_right_q     <= '0;
      cmd_dir_left_q  <= DIR_FWD;
      cmd_dir_right_q <= DIR_FWD;
      cmd_hold_q      <= '0;
      cmd_done        <= 1'b0;
      cmd_abort       <= 1'b0;
    end else begin
      cmd_done  <= 1'b0;
      cmd_abort <= 1'b0;
      if (lf_valid) begin
        lf_left_q  <= lf_duty_left;
        lf_right_q <= lf_duty_right;
      end
      // Emergency stop pre-empts everything, including a hold that would expire this tick.
      if (estop) begin
        state     <= STOP;
        cmd_abort <= (state == MANEUVER) || (state == HOLD);
      end else begin
        case (state)
          FOLLOW: begin
            if (accept) begin
              cmd_left_q      <= cmd_duty_left;
              cmd_right_q     <= cmd_duty_right;
              cmd_dir_left_q  <= cmd_dir_left;
              cmd_dir_right_q <= cmd_dir_right;
              cmd_hold_q      <= cmd_hold;
              state           <= MANEUVER;
            end
          end
          MANEUVER: begin
            if (tick && settled_left && settled_right) begin
              hold_cnt <= cmd_hold_q;
              state    <= HOLD;
            end
          end
          HOLD: begin
            if (tick) begin
              if (hold_cnt == '0) begin
                cmd_done <= 1'b1;
                state    <= FOLLOW;
              end else begin
                hold_cnt <= hold_cnt - 1'b1;
              end
            end
          end
          STOP:    state <= FOLLOW;
          default: state <= FOLLOW;
        endcase
      end
    end
  end

  duty_ramp_channel #(.RAMP_STEP(RAMP_STEP)) u_left (
    .clk_3125KHz (clk_3125KHz),
    .rst         (rst),
    .tick        (tick),
    .estop       (estop),
    .target_duty (tgt_duty_left),
    .target_dir  (tgt_dir_left),
    .duty        (duty_left),
    .dir         (dir_left),
    .settled     (settled_left)
  );

  duty_ramp_channel #(.RAMP_STEP(RAMP_STEP)) u_right (
    .clk_3125KHz (clk_3125KHz),
    .rst         (rst),
    .tick        (tick),
    .estop       (estop),
    .target_duty (tgt_duty_right),
    .target_dir  (tgt_dir_right),
    .duty        (duty_right),
    .dir         (dir_right),
    .settled     (settled_right)
  );

endmodule

// File: tb/tb_motor_speed_scheduler.sv
// Scoreboard bench: stimulus queues hand-computed output events, a forked monitor pops them on every output change or pulse.
module tb_motor_speed_scheduler;

  localparam int RAMP_DIV = 4;

  typedef struct packed {
    logic [3:0] dl;
    logic [3:0] dr;
    logic       dirl;
    logic       dirr;
    logic       done;
    logic       abort;
  } ev_t;

  logic       clk_3125KHz;
  logic       rst;
  logic       estop;
  logic       lf_valid;
  logic [3:0] lf_duty_left, lf_duty_right;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_duty_left, cmd_duty_right;
  logic       cmd_dir_left, cmd_dir_right;
  logic [7:0] cmd_hold;
  logic       cmd_done, cmd_abort;
  logic [3:0] duty_left, duty_right;
  logic       dir_left, dir_right;
  logic       busy;

  ev_t exp_q[$];
  int  vectors;
  int  miscompares;
  bit  armed;

  motor_speed_scheduler #(.RAMP_DIV(RAMP_DIV), .RAMP_STEP(1), .HOLD_W(8)) dut (
    .clk_3125KHz    (clk_3125KHz),
    .rst            (rst),
    .estop          (estop),
    .lf_valid       (lf_valid),
    .lf_duty_left   (lf_duty_left),
    .lf_duty_right  (lf_duty_right),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_duty_left  (cmd_duty_left),
    .cmd_duty_right (cmd_duty_right),
    .cmd_dir_left   (cmd_dir_left),
    .cmd_dir_right  (cmd_dir_right),
    .cmd_hold       (cmd_hold),
    .cmd_done       (cmd_done),
    .cmd_abort      (cmd_abort),
    .duty_left      (duty_left),
    .duty_right     (duty_right),
    .dir_left       (dir_left),
    .dir_right      (dir_right),
    .busy           (busy)
  );

  initial clk_3125KHz = 1'b0;
  always #5 clk_3125KHz = ~clk_3125KHz;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, expv);
    end
  endtask

  task automatic expectEvent(input logic [3:0] dl, input logic [3:0] dr, input logic dirl,
                             input logic dirr, input logic done, input logic abort);
    ev_t e;
    e.dl = dl; e.dr = dr; e.dirl = dirl; e.dirr = dirr; e.done = done; e.abort = abort;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic lfv, input logic [3:0] lfl, input logic [3:0] lfr,
                               input logic cv, input logic [3:0] cl, input logic [3:0] cr,
                               input logic cdl, input logic cdr, input logic [7:0] ch,
                               input logic es, input int cycles);
    lf_valid = lfv; lf_duty_left = lfl; lf_duty_right = lfr;
    cmd_valid = cv; cmd_duty_left = cl; cmd_duty_right = cr;
    cmd_dir_left = cdl; cmd_dir_right = cdr; cmd_hold = ch;
    estop = es;
    repeat (cycles) @(negedge clk_3125KHz);
  endtask

  task automatic idle(input logic es, input int cycles);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 8'd0, es, cycles);
  endtask

  task automatic waitDrain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk_3125KHz);
      n++;
    end
    checkOutput({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Left 5 -> 8 fwd, right 5 fwd -> 3 rev: three ticks up, five down, one flip, three up.
  task automatic expectManeuverTo83();
    expectEvent(4'd6, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    expectEvent(4'd7, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    expectEvent(4'd8, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    expectEvent(4'd8, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    expectEvent(4'd8, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    expectEvent(4'd8, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    expectEvent(4'd8, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    expectEvent(4'd8, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    expectEvent(4'd8, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic monitor();
    logic [9:0] prev_outs;
    logic [9:0] outs;
    ev_t        cur;
    int         k;
    prev_outs = '0;
    k = 0;
    forever begin
      @(posedge clk_3125KHz);
      #1;
      if (rst) k = 0; else k++;
      outs = {duty_left, duty_right, dir_left, dir_right};
      cur  = {outs, cmd_done, cmd_abort};
      if (armed && (outs !== prev_outs || cmd_done !== 1'b0 || cmd_abort !== 1'b0)) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_event: got %0h, required no event", cur);
        end else begin
          checkOutput("event", 32'(cur), 32'(exp_q.pop_front()));
        end
        if (outs !== prev_outs && !rst && !estop)
          checkOutput("tick_align", 32'(k % RAMP_DIV), 32'd0);
      end
      prev_outs = outs;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    armed = 1'b0;
    rst = 1'b1;
    idle(1'b0, 0);
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk_3125KHz);
    checkOutput("reset_duty_left", 32'(duty_left), 32'd0);
    checkOutput("reset_duty_right", 32'(duty_right), 32'd0);
    checkOutput("reset_dirs", 32'({dir_left, dir_right}), 32'd3);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_pulses", 32'({cmd_done, cmd_abort}), 32'd0);
    rst = 1'b0;
    armed = 1'b1;
    idle(1'b0, 2);

    $display("[TB] line follower ramp to 10/6");
    for (int d = 1; d <= 10; d++)
      expectEvent(4'(d), (d > 6) ? 4'd6 : 4'(d), 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd10, 4'd6, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1);
    for (int i = 0; i < 48; i++) begin
      if (i % 8 == 0) checkOutput("ready_follow", 32'(cmd_ready), 32'd1);
      idle(1'b0, 1);
    end
    waitDrain(8, "lf_ramp");

    $display("[TB] settle at 5/5, then maneuver 8 fwd / 3 rev hold 2");
    for (int d = 9; d >= 5; d--)
      expectEvent(4'(d), 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd5, 4'd5, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1);
    idle(1'b0, 0);
    waitDrain(30, "lf_settle");
    expectManeuverTo83();
    expectEvent(4'd8, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    expectEvent(4'd7, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    expectEvent(4'd6, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    expectEvent(4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int d = 0; d <= 5; d++)
      expectEvent(4'd5, 4'(d), 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("ready_before_cmd", 32'(cmd_ready), 32'd1);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd8, 4'd3, 1'b1, 1'b0, 8'd2, 1'b0, 1);
    idle(1'b0, 1);
    checkOutput("busy_maneuver", 32'(busy), 32'd1);
    checkOutput("ready_maneuver", 32'(cmd_ready), 32'd0);
    waitDrain(100, "maneuver_done");
    checkOutput("busy_after_done", 32'(busy), 32'd0);

    $display("[TB] estop during hold, ignored commands, release");
    expectManeuverTo83();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd8, 4'd3, 1'b1, 1'b0, 8'd20, 1'b0, 1);
    idle(1'b0, 2);
    checkOutput("ready_busy", 32'(cmd_ready), 32'd0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd15, 4'd15, 1'b1, 1'b1, 8'd0, 1'b0, 3);
    idle(1'b0, 0);
    waitDrain(60, "maneuver_hold");
    checkOutput("busy_hold", 32'(busy), 32'd1);
    expectEvent(4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'd6, 4'd6, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 8'd0, 1'b1, 1);
    checkOutput("ready_estop", 32'(cmd_ready), 32'd0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd12, 4'd12, 1'b0, 1'b0, 8'd0, 1'b1, 4);
    idle(1'b1, 8);
    checkOutput("busy_stop", 32'(busy), 32'd1);
    waitDrain(1, "abort");
    expectEvent(4'd1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int d = 2; d <= 6; d++)
      expectEvent(4'(d), 4'(d - 1), 1'b1, 1'b1, 1'b0, 1'b0);
    expectEvent(4'd6, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1);
    waitDrain(40, "estop_release");
    checkOutput("busy_release", 32'(busy), 32'd0);

    $display("[TB] zero-hold command at current duties");
    expectEvent(4'd6, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("ready_hold0", 32'(cmd_ready), 32'd1);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd6, 4'd6, 1'b1, 1'b1, 8'd0, 1'b0, 1);
    idle(1'b0, 0);
    waitDrain(9, "hold0_done");
    checkOutput("busy_hold0", 32'(busy), 32'd0);

    $display("[TB] reset mid-reversal");
    expectEvent(4'd6, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    expectEvent(4'd6, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    expectEvent(4'd6, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd6, 4'd6, 1'b1, 1'b0, 8'd0, 1'b0, 1);
    idle(1'b0, 0);
    waitDrain(20, "reversal_start");
    expectEvent(4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk_3125KHz);
    rst = 1'b0;
    waitDrain(1, "reset_event");
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_pulses", 32'({cmd_done, cmd_abort}), 32'd0);
    idle(1'b0, 20);
    checkOutput("rst_quiet_duties", 32'({duty_left, duty_right}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
